// File: rtl/data_packer.sv
// ============================================================================
// Module   : data_packer
// Purpose  : Packs a qualified serial bit stream into bytes. Completed bytes
//            are queued in a small circular FIFO. The head byte is held
//            steady on a register for a combinational downstream consumer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module data_packer #(
  parameter int MSB_FIRST = 1,  // 1: first bit -> rx_data[7]; 0: first bit -> rx_data[0]
  parameter int DEPTH     = 4   // FIFO depth in bytes, power of 2, >= 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     bit_i,
  input  logic                     bit_valid_i,
  input  logic                     frame_clr_i,
  input  logic                     data_read_i,
  input  logic                     err_clr_i,
  output logic [7:0]               rx_data_o,
  output logic                     data_ready_o,
  output logic [$clog2(DEPTH):0]   fifo_count_o,
  output logic [2:0]               bit_count_o,
  output logic                     overrun_error_o
);

  localparam int               PTR_W   = $clog2(DEPTH);
  localparam int               CNT_W   = PTR_W + 1;
  localparam logic [CNT_W-1:0] C_DEPTH = CNT_W'(DEPTH);
  localparam logic [PTR_W-1:0] C_PTR_1 = PTR_W'(1);

  // Architectural state
  logic [7:0]       shift_q,    shift_d;
  logic [2:0]       bit_cnt_q,  bit_cnt_d;
  logic [PTR_W-1:0] wr_ptr_q,   wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q,   rd_ptr_d;
  logic [CNT_W-1:0] count_q,    count_d;
  logic [7:0]       rx_data_q,  rx_data_d;
  logic             overrun_q,  overrun_d;
  logic [7:0]       mem_q [DEPTH];

  // Intermediate decode
  logic [7:0]       w_shift_in;
  logic             w_byte_done;
  logic             w_empty;
  logic             w_full;
  logic             w_pop;
  logic             w_push;
  logic             w_drop;
  logic [PTR_W-1:0] w_rd_ptr_nxt;

  // Shift-in direction is fixed by the bit order parameter.
  assign w_shift_in = (MSB_FIRST != 0) ? {shift_q[6:0], bit_i}
                                       : {bit_i, shift_q[7:1]};

  // Bit accumulation; frame_clr wins over a coincident valid bit.
  always_comb begin
    shift_d     = shift_q;
    bit_cnt_d   = bit_cnt_q;
    w_byte_done = 1'b0;
    if (frame_clr_i) begin
      shift_d   = 8'h00;
      bit_cnt_d = 3'd0;
    end else if (bit_valid_i) begin
      shift_d     = w_shift_in;
      bit_cnt_d   = bit_cnt_q + 3'd1;
      w_byte_done = (bit_cnt_q == 3'd7);
    end
  end

  assign w_empty      = (count_q == '0);
  assign w_full       = (count_q == C_DEPTH);
  // A pop on an empty FIFO is ignored, even if a byte lands this cycle.
  assign w_pop        = data_read_i && !w_empty;
  // A concurrent pop frees the slot a full FIFO needs for the new byte.
  assign w_push       = w_byte_done && (!w_full || w_pop);
  assign w_drop       = w_byte_done && !w_push;
  assign w_rd_ptr_nxt = rd_ptr_q + C_PTR_1;

  // FIFO pointer/count update, head-byte selection and sticky overrun.
  always_comb begin
    wr_ptr_d  = w_push ? (wr_ptr_q + C_PTR_1) : wr_ptr_q;
    rd_ptr_d  = w_pop  ? w_rd_ptr_nxt         : rd_ptr_q;
    count_d   = count_q + CNT_W'(w_push) - CNT_W'(w_pop);
    rx_data_d = rx_data_q;
    if (w_pop) begin
      // With one entry left, the next head is either the byte being
      // written right now or nothing.
      if (count_q == CNT_W'(1)) begin
        rx_data_d = w_push ? w_shift_in : 8'h00;
      end else begin
        rx_data_d = mem_q[w_rd_ptr_nxt];
      end
    end else if (w_push && w_empty) begin
      rx_data_d = w_shift_in;
    end
    overrun_d = overrun_q;
    if (err_clr_i) begin
      overrun_d = 1'b0;
    end
    if (w_drop) begin
      overrun_d = 1'b1;
    end
  end

  // Control and output registers, cleared asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift_q   <= 8'h00;
      bit_cnt_q <= 3'd0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      rx_data_q <= 8'h00;
      overrun_q <= 1'b0;
    end else begin
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      rx_data_q <= rx_data_d;
      overrun_q <= overrun_d;
    end
  end

  // Byte storage; contents are only observed through valid pointers.
  always_ff @(posedge clk) begin
    if (w_push) begin
      mem_q[wr_ptr_q] <= w_shift_in;
    end
  end

  assign rx_data_o       = rx_data_q;
  assign data_ready_o    = !w_empty;
  assign fifo_count_o    = count_q;
  assign bit_count_o     = bit_cnt_q;
  assign overrun_error_o = overrun_q;

endmodule

`default_nettype wire

// File: tb/tb_data_packer.sv
// ============================================================================
// Module   : tb_data_packer
// Purpose  : Self-checking bench for data_packer. Two instances (MSB-first
//            and LSB-first) share one stimulus stream and are compared with
//            a queue-based reference model, a directed vector table and
//            hand-written corner-case sequences.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_data_packer;

  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk;
  logic          rst;
  logic          bit_i;
  logic          bit_valid;
  logic          frame_clr;
  logic          data_read;
  logic          err_clr;

  logic [7:0]    m_rx,  l_rx;
  logic          m_rdy, l_rdy;
  logic [CW-1:0] m_cnt, l_cnt;
  logic [2:0]    m_bc,  l_bc;
  logic          m_ovr, l_ovr;

  int checks;
  int errors;

  data_packer #(.MSB_FIRST(1), .DEPTH(DEPTH)) u_dut_msb (
    .clk            (clk),
    .rst            (rst),
    .bit_i          (bit_i),
    .bit_valid_i    (bit_valid),
    .frame_clr_i    (frame_clr),
    .data_read_i    (data_read),
    .err_clr_i      (err_clr),
    .rx_data_o      (m_rx),
    .data_ready_o   (m_rdy),
    .fifo_count_o   (m_cnt),
    .bit_count_o    (m_bc),
    .overrun_error_o(m_ovr)
  );

  data_packer #(.MSB_FIRST(0), .DEPTH(DEPTH)) u_dut_lsb (
    .clk            (clk),
    .rst            (rst),
    .bit_i          (bit_i),
    .bit_valid_i    (bit_valid),
    .frame_clr_i    (frame_clr),
    .data_read_i    (data_read),
    .err_clr_i      (err_clr),
    .rx_data_o      (l_rx),
    .data_ready_o   (l_rdy),
    .fifo_count_o   (l_cnt),
    .bit_count_o    (l_bc),
    .overrun_error_o(l_ovr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  bit         mdl_bits[$];
  logic [7:0] mdl_qm[$];
  logic [7:0] mdl_ql[$];
  bit         mdl_ovr;

  task automatic model_reset();
    mdl_bits.delete();
    mdl_qm.delete();
    mdl_ql.delete();
    mdl_ovr = 1'b0;
  endtask

  task automatic model_step(input logic bv, input logic b, input logic fc,
                            input logic dr, input logic ec);
    bit         done;
    bit         pop;
    logic [7:0] bm;
    logic [7:0] bl;
    done = 1'b0;
    bm   = 8'h00;
    bl   = 8'h00;
    pop  = dr && (mdl_qm.size() > 0);
    if (fc) begin
      mdl_bits.delete();
    end else if (bv) begin
      mdl_bits.push_back(b);
      if (mdl_bits.size() == 8) begin
        for (int i = 0; i < 8; i++) begin
          bm[7-i] = mdl_bits[i];
          bl[i]   = mdl_bits[i];
        end
        done = 1'b1;
        mdl_bits.delete();
      end
    end
    if (pop) begin
      void'(mdl_qm.pop_front());
      void'(mdl_ql.pop_front());
    end
    if (ec) mdl_ovr = 1'b0;
    if (done) begin
      if (mdl_qm.size() < DEPTH) begin
        mdl_qm.push_back(bm);
        mdl_ql.push_back(bl);
      end else begin
        mdl_ovr = 1'b1;
      end
    end
  endtask

  // ---------------- checking helpers ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_model();
    chk("mdl_rx_msb",  32'(m_rx),  (mdl_qm.size() > 0) ? 32'(mdl_qm[0]) : 32'h0);
    chk("mdl_rx_lsb",  32'(l_rx),  (mdl_ql.size() > 0) ? 32'(mdl_ql[0]) : 32'h0);
    chk("mdl_cnt_msb", 32'(m_cnt), 32'(mdl_qm.size()));
    chk("mdl_cnt_lsb", 32'(l_cnt), 32'(mdl_ql.size()));
    chk("mdl_rdy",     32'(m_rdy), 32'(mdl_qm.size() > 0));
    chk("mdl_rdy_lsb", 32'(l_rdy), 32'(mdl_ql.size() > 0));
    chk("mdl_bc",      32'(m_bc),  32'(mdl_bits.size()));
    chk("mdl_bc_lsb",  32'(l_bc),  32'(mdl_bits.size()));
    chk("mdl_ovr",     32'(m_ovr), 32'(mdl_ovr));
    chk("mdl_ovr_lsb", 32'(l_ovr), 32'(mdl_ovr));
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_rx_msb"}, 32'(m_rx),  32'h0);
    chk({tag, "_rx_lsb"}, 32'(l_rx),  32'h0);
    chk({tag, "_cnt"},    32'(m_cnt), 32'h0);
    chk({tag, "_rdy"},    32'(m_rdy), 32'h0);
    chk({tag, "_bc"},     32'(m_bc),  32'h0);
    chk({tag, "_ovr"},    32'(m_ovr), 32'h0);
    chk({tag, "_lsb_all"}, {l_rdy, l_cnt, l_bc, l_ovr}, 32'h0);
  endtask

  // One clock with the given inputs, model update, then output check.
  task automatic cycle(input logic bv, input logic b, input logic fc,
                       input logic dr, input logic ec);
    bit_valid = bv;
    bit_i     = b;
    frame_clr = fc;
    data_read = dr;
    err_clr   = ec;
    @(posedge clk);
    model_step(bv, b, fc, dr, ec);
    #1;
    bit_valid = 1'b0;
    bit_i     = 1'b0;
    frame_clr = 1'b0;
    data_read = 1'b0;
    err_clr   = 1'b0;
    check_model();
  endtask

  // Sends a byte MSB first; the pop strobe may ride on the 8th bit.
  task automatic send_byte(input logic [7:0] v, input logic dr_on_last);
    for (int i = 7; i >= 0; i--) begin
      cycle(1'b1, v[i], 1'b0, (i == 0) ? dr_on_last : 1'b0, 1'b0);
    end
  endtask

  // Checks the head byte on the MSB-first instance, then pops it.
  task automatic pop_expect(input string name, input logic [7:0] exp);
    chk(name, 32'(m_rx), 32'(exp));
    cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic       bv;
    logic       b;
    logic       dr;
    logic [7:0] rx_m;
    logic [7:0] rx_l;
    int         cnt;
    int         bc;
    logic       rdy;
  } vec_t;

  localparam int NVEC = 18;
  vec_t vecs[NVEC];

  task automatic fill_byte_vectors(input int base, input logic [7:0] pat,
                                   input logic [7:0] exp_m, input logic [7:0] exp_l);
    for (int i = 0; i < 8; i++) begin
      vecs[base+i].bv   = 1'b1;
      vecs[base+i].b    = pat[7-i];
      vecs[base+i].dr   = 1'b0;
      vecs[base+i].rx_m = (i == 7) ? exp_m : 8'h00;
      vecs[base+i].rx_l = (i == 7) ? exp_l : 8'h00;
      vecs[base+i].cnt  = (i == 7) ? 1 : 0;
      vecs[base+i].bc   = (i == 7) ? 0 : i + 1;
      vecs[base+i].rdy  = (i == 7);
    end
    vecs[base+8] = '{bv: 1'b0, b: 1'b0, dr: 1'b1, rx_m: 8'h00, rx_l: 8'h00,
                     cnt: 0, bc: 0, rdy: 1'b0};
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    rst       = 1'b1;
    bit_i     = 1'b0;
    bit_valid = 1'b0;
    frame_clr = 1'b0;
    data_read = 1'b0;
    err_clr   = 1'b0;
    model_reset();

    fill_byte_vectors(0, 8'hA5, 8'hA5, 8'hA5);
    fill_byte_vectors(9, 8'h01, 8'h01, 8'h80);

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst = 1'b0;

    // Table-driven: A5 palindrome and 01 bit-order check
    for (int i = 0; i < NVEC; i++) begin
      cycle(vecs[i].bv, vecs[i].b, 1'b0, vecs[i].dr, 1'b0);
      chk($sformatf("vec%0d_rx_msb", i), 32'(m_rx),  32'(vecs[i].rx_m));
      chk($sformatf("vec%0d_rx_lsb", i), 32'(l_rx),  32'(vecs[i].rx_l));
      chk($sformatf("vec%0d_cnt", i),    32'(m_cnt), 32'(vecs[i].cnt));
      chk($sformatf("vec%0d_bc", i),     32'(m_bc),  32'(vecs[i].bc));
      chk($sformatf("vec%0d_rdy", i),    32'(m_rdy), 32'(vecs[i].rdy));
    end

    // Overrun: five bytes into a four-deep FIFO
    send_byte(8'h11, 1'b0);
    send_byte(8'h22, 1'b0);
    send_byte(8'h33, 1'b0);
    send_byte(8'h44, 1'b0);
    chk("full_no_ovr", 32'(m_ovr), 32'h0);
    send_byte(8'h55, 1'b0);
    chk("ovr_cnt", 32'(m_cnt), 32'd4);
    chk("ovr_flag", 32'(m_ovr), 32'h1);
    pop_expect("ovr_pop0", 8'h11);
    pop_expect("ovr_pop1", 8'h22);
    pop_expect("ovr_pop2", 8'h33);
    pop_expect("ovr_pop3", 8'h44);
    chk("ovr_empty", 32'(m_cnt), 32'd0);
    chk("ovr_sticky", 32'(m_ovr), 32'h1);
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("err_clr", 32'(m_ovr), 32'h0);

    // Full FIFO with write and pop on the same edge
    send_byte(8'h11, 1'b0);
    send_byte(8'h22, 1'b0);
    send_byte(8'h33, 1'b0);
    send_byte(8'h44, 1'b0);
    send_byte(8'h66, 1'b1);
    chk("wp_cnt", 32'(m_cnt), 32'd4);
    chk("wp_ovr", 32'(m_ovr), 32'h0);
    pop_expect("wp_pop0", 8'h22);
    pop_expect("wp_pop1", 8'h33);
    pop_expect("wp_pop2", 8'h44);
    pop_expect("wp_pop3", 8'h66);

    // frame_clr over a coincident bit, then a clean byte
    cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("fc_pre_bc", 32'(m_bc), 32'd3);
    cycle(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("fc_bc", 32'(m_bc), 32'd0);
    send_byte(8'hC3, 1'b0);
    chk("fc_cnt", 32'(m_cnt), 32'd1);
    pop_expect("fc_rx", 8'hC3);
    cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("empty_pop_cnt", 32'(m_cnt), 32'd0);

    // Asynchronous reset mid-cycle with data buffered and bits pending
    send_byte(8'h5A, 1'b0);
    send_byte(8'h96, 1'b0);
    for (int i = 0; i < 5; i++) cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("pre_rst_cnt", 32'(m_cnt), 32'd2);
    #2;
    rst = 1'b1;
    #1;
    check_all_zero("async_rst");
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    send_byte(8'h3C, 1'b0);
    chk("post_rst_cnt", 32'(m_cnt), 32'd1);
    pop_expect("post_rst_rx", 8'h3C);
    chk("post_rst_empty", 32'(m_cnt), 32'd0);

    // Randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      int unsigned pr;
      pr = (n < 1500) ? 6 : 20;
      cycle($urandom_range(99) < 75,
            1'($urandom),
            $urandom_range(99) < 3,
            $urandom_range(99) < pr,
            $urandom_range(99) < 4);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/data_packer.md
# data_packer

Serial-to-parallel front end of the data path. It collects a qualified serial bit stream into 8-bit bytes and buffers the completed bytes in a small FIFO. It presents the head byte on `rx_data` to the downstream encrypt stage, which is purely combinational and therefore needs a stable byte. The consumer pops bytes with a one-cycle `data_read` strobe, and overflow is flagged with a sticky error.

## Interface
- `MSB_FIRST`, default 1: 1 means the first received bit lands in `rx_data[7]`; 0 means the first bit lands in `rx_data[0]`.
- `DEPTH`, default 4: FIFO depth in bytes. Must be a power of 2 and ≥ 2.

- `clk`  in  1: single clock; all state updates on its rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `bit_in`  in  1: serial data bit, sampled only when `bit_valid`=1.
- `bit_valid`  in  1: qualifies `bit_in` for one cycle.
- `frame_clr`  in  1: synchronous discard of the partial byte. FIFO contents are untouched.
- `data_read`  in  1: one-cycle pop strobe from the consumer.
- `err_clr`  in  1: synchronous clear of `overrun_error`.
- `rx_data`  out  8: head-of-FIFO byte, registered. Reads 8'h00 while the FIFO is empty.
- `data_ready`  out  1: level, high while the FIFO is non-empty.
- `fifo_count`  out  $clog2(DEPTH)+1: number of bytes held, 0..DEPTH.
- `bit_count`  out  3: number of bits accumulated in the partial byte, 0..7.
- `overrun_error`  out  1: sticky; set when a completed byte is dropped.

## Operation
- Shift register and 3-bit bit counter.
  - Each `bit_valid` cycle shifts `bit_in` in, following `MSB_FIRST`.
  - On the 8th bit the counter wraps 7→0 and the completed byte is offered to the FIFO on the same edge.
- FIFO is a circular buffer with read/write pointers of `$clog2(DEPTH)` bits that wrap modulo DEPTH, plus an occupancy counter.
- Write: the completed byte is written if `fifo_count < DEPTH`, or if `data_read` is accepted in the same cycle.
- Full FIFO: if the FIFO is full and there is no concurrent pop, the byte is dropped. `overrun_error` is set and the pointers and count are unchanged.
- Pop: `data_read` with `data_ready`=1 advances the read pointer and decrements `fifo_count`. `data_read` while empty is ignored with no underflow, and the count stays 0.
- Simultaneous write and pop on a non-empty FIFO: both happen and `fifo_count` is unchanged.
- Simultaneous write and pop on an empty FIFO: the pop is ignored and the write lands, giving count 1.
- `frame_clr` has priority over `bit_valid` in the same cycle. The counter goes to 0, the shift register goes to 0, and the bit is discarded; a byte that would have completed on that cycle is discarded as well.
- `overrun_error` set and `err_clr` in the same cycle: set wins.
- `rx_data` is a register loaded with the new head after every push or pop. A write into an empty FIFO loads the written byte directly.

## Timing
- All outputs reset to 0 asynchronously: `rx_data`=8'h00, `data_ready`=0, `fifo_count`=0, `bit_count`=0, `overrun_error`=0. The shift register and pointers also reset to 0.
- Reset mid-byte or with bytes buffered discards everything. Operation resumes on the first rising edge after `rst` deasserts.
- Latency: the 8th `bit_valid` is sampled at edge N. Then `data_ready`=1, `rx_data` is valid and `fifo_count` is incremented from cycle N+1 onward.
- Pop: `data_read` is sampled at edge M. The next byte, or 8'h00 if the FIFO became empty, appears on `rx_data` from cycle M+1.
- Throughput: one bit per cycle, which is one byte per 8 cycles. A sustained pop of one byte per 8 cycles never overruns.
- `bit_valid` gaps of any length are allowed; partial state holds indefinitely.

## Test plan
- Reset then serial 1,0,1,0,0,1,0,1 (`MSB_FIRST`=1) -> `data_ready`=1 and `rx_data`=8'hA5 one cycle after the 8th bit, with `fifo_count`=1 and `bit_count`=0.
- `MSB_FIRST`=0, same bit sequence -> `rx_data`=8'hA5 bit-reversed, i.e. 8'hA5 again (palindrome check). Repeat with bits of 8'h01 sent MSB order -> `rx_data`=8'h80.
- Push 5 bytes 8'h11..8'h55 into DEPTH=4 with no reads -> `fifo_count`=4 and `overrun_error`=1. Pops then return 11, 22, 33, 44; 55 is lost. `err_clr` -> `overrun_error`=0.
- FIFO full, and the 8th bit of 8'h66 arrives in the same cycle as `data_read` -> no overrun and `fifo_count` stays 4. The next pops return 22, 33, 44, 66.
- 3 bits, then `frame_clr` together with `bit_valid`, then a full byte 8'hC3 -> `bit_count` is 0 after the clear and the FIFO receives only 8'hC3. `data_read` on an empty FIFO -> `fifo_count` stays 0.
- `rst` asserted asynchronously, mid-clock, with 2 bytes buffered and 5 bits pending -> all outputs are 0 immediately. A new byte 8'h3C after release is the only byte seen.
